// File: rtl/fabric_ctrl_pkg.sv
// fabric_ctrl_pkg: shared states, opcodes and counter width for the fabric GSR controller
package fabric_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    CFG,
    RST,
    SET,
    SETTLE,
    RUN,
    FROZEN
  } state_e;

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_FRZ = 2'b10;
  localparam logic [1:0] OP_UNF = 2'b11;

endpackage

// File: rtl/gsr_pulse_timer.sv
// gsr_pulse_timer: loadable down-counter that stops at zero and flags it
module gsr_pulse_timer
  import fabric_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (load)
      r_cnt <= load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign value = r_cnt;
  assign zero  = (r_cnt == '0);

endmodule

// File: rtl/fabric_ff_gsr_ctrl.sv
// fabric_ff_gsr_ctrl: sequences global set/reset pulses and clock gating for the fabric DFFSRQ array
module fabric_ff_gsr_ctrl
  import fabric_ctrl_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_done,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       ff_reset,
  output logic       ff_set,
  output logic       ff_clk_en,
  output logic       busy,
  output logic       done
);

  state_e           r_state;
  state_e           w_next;
  logic             r_ff_reset;
  logic             r_ff_set;
  logic             r_clk_en;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_load;
  logic             w_zero;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt_unused;

  assign w_accept = req_valid && r_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      CFG:         w_next = RST;
      RST, SET:    w_next = w_zero ? SETTLE : r_state;
      SETTLE:      w_next = w_zero ? RUN : SETTLE;
      RUN, FROZEN: w_next = !w_accept           ? r_state :
                            (req_op == OP_RST)  ? RST :
                            (req_op == OP_SET)  ? SET :
                            (req_op == OP_FRZ)  ? FROZEN : RUN;
      default:     w_next = CFG;
    endcase
    if (!cfg_done)
      w_next = CFG;
  end

  // Counter reloads on every state change so each pulse/settle phase is timed from its own entry
  assign w_load     = (w_next != r_state);
  assign w_load_val = (w_next == RST || w_next == SET) ? CNT_W'(PULSE_CYCLES - 1) :
                      (w_next == SETTLE)               ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  gsr_pulse_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .value    (w_cnt_unused),
    .zero     (w_zero)
  );

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CFG;
      r_ff_reset <= 1'b1;
      r_ff_set   <= 1'b0;
      r_clk_en   <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ff_reset <= (w_next == CFG) || (w_next == RST);
      r_ff_set   <= (w_next == SET);
      r_clk_en   <= (w_next == RUN);
      r_ready    <= (w_next == RUN) || (w_next == FROZEN);
      r_busy     <= !((w_next == RUN) || (w_next == FROZEN));
      r_done     <= (r_state == SETTLE) && (w_next == RUN);
    end
  end

  assign ff_reset  = r_ff_reset;
  assign ff_set    = r_ff_set;
  assign ff_clk_en = r_clk_en;
  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fabric_ff_gsr_ctrl.sv
// tb_fabric_ff_gsr_ctrl: directed and random-stream checks of the fabric GSR controller
module tb_fabric_ff_gsr_ctrl;

  localparam int P = 4;
  localparam int S = 2;

  logic       clk;
  logic       reset;
  logic       cfg_done;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       ff_reset;
  logic       ff_set;
  logic       ff_clk_en;
  logic       busy;
  logic       done;
  int         n_checks = 0;
  int         n_fail = 0;

  wire [5:0] obs = {ff_reset, ff_set, ff_clk_en, req_ready, busy, done};

  fabric_ff_gsr_ctrl #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_done  (cfg_done),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .ff_reset  (ff_reset),
    .ff_set    (ff_set),
    .ff_clk_en (ff_clk_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] e [8] = '{6'b100010, 6'b100010, 6'b100010, 6'b100010,
                          6'b000010, 6'b000010, 6'b001101, 6'b001100};
    reset = 1'b1; cfg_done = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (obs !== 6'b100010) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 6'b100010); end
    n_checks++;
    if (dut.u_timer.value !== 8'd0) begin n_fail++; $display("FAIL reset_counter: got %0d want 0", dut.u_timer.value); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL reset_seq[%0d]: got %b want %b", i, obs, e[i]); end
    end
  endtask

  task automatic test_set;
    logic [5:0] e [8] = '{6'b010010, 6'b010010, 6'b010010, 6'b010010,
                          6'b000010, 6'b000010, 6'b001101, 6'b001100};
    req_valid = 1'b1; req_op = 2'b01;
    for (int i = 0; i < 8; i++) begin
      step();
      req_valid = 1'b0;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL set_seq[%0d]: got %b want %b", i, obs, e[i]); end
    end
  endtask

  task automatic test_freeze;
    logic [8:0] t [6] = '{{3'b111, 6'b001100}, {3'b110, 6'b000100}, {3'b000, 6'b000100},
                          {3'b110, 6'b000100}, {3'b111, 6'b001100}, {3'b000, 6'b001100}};
    for (int i = 0; i < 6; i++) begin
      {req_valid, req_op} = t[i][8:6];
      step();
      n_checks++;
      if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL freeze_seq[%0d]: got %b want %b", i, obs, t[i][5:0]); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_ignore_busy;
    logic [8:0] t [9] = '{{3'b100, 6'b100010}, {3'b110, 6'b100010}, {3'b110, 6'b100010},
                          {3'b110, 6'b100010}, {3'b110, 6'b000010}, {3'b110, 6'b000010},
                          {3'b000, 6'b001101}, {3'b000, 6'b001100}, {3'b000, 6'b001100}};
    for (int i = 0; i < 9; i++) begin
      {req_valid, req_op} = t[i][8:6];
      step();
      n_checks++;
      if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL ignore_seq[%0d]: got %b want %b", i, obs, t[i][5:0]); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_cfg_drop;
    logic [9:0] t [20] = '{{4'b1101, 6'b010010}, {4'b1000, 6'b010010}, {4'b0110, 6'b100010},
                           {4'b0110, 6'b100010}, {4'b1000, 6'b100010}, {4'b1000, 6'b100010},
                           {4'b1000, 6'b100010}, {4'b1000, 6'b100010}, {4'b1000, 6'b000010},
                           {4'b1000, 6'b000010}, {4'b1000, 6'b001101}, {4'b0101, 6'b100010},
                           {4'b1000, 6'b100010}, {4'b1000, 6'b100010}, {4'b1000, 6'b100010},
                           {4'b1000, 6'b100010}, {4'b1000, 6'b000010}, {4'b1000, 6'b000010},
                           {4'b1000, 6'b001101}, {4'b1000, 6'b001100}};
    for (int i = 0; i < 20; i++) begin
      {cfg_done, req_valid, req_op} = t[i][9:6];
      step();
      n_checks++;
      if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL cfg_drop_seq[%0d]: got %b want %b", i, obs, t[i][5:0]); end
    end
    cfg_done = 1'b1; req_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [5:0] e [8] = '{6'b100010, 6'b100010, 6'b100010, 6'b100010,
                          6'b000010, 6'b000010, 6'b001101, 6'b001100};
    req_valid = 1'b1; req_op = 2'b00;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    n_checks++;
    if (obs !== 6'b000010) begin n_fail++; $display("FAIL settle_before_reset: got %b want %b", obs, 6'b000010); end
    n_checks++;
    if (dut.u_timer.value !== 8'd1) begin n_fail++; $display("FAIL settle_counter: got %0d want 1", dut.u_timer.value); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 6'b100010) begin n_fail++; $display("FAIL async_outputs: got %b want %b", obs, 6'b100010); end
    n_checks++;
    if (dut.u_timer.value !== 8'd0) begin n_fail++; $display("FAIL async_counter: got %0d want 0", dut.u_timer.value); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL async_recover[%0d]: got %b want %b", i, obs, e[i]); end
    end
  endtask

  function automatic logic [5:0] m_out(int st, bit dn);
    case (st)
      0, 1:    return 6'b100010;
      2:       return 6'b010010;
      3:       return 6'b000010;
      4:       return {5'b00110, dn};
      default: return 6'b000100;
    endcase
  endfunction

  // Model states: 0 CFG, 1 RST, 2 SET, 3 SETTLE, 4 RUN, 5 FROZEN; left = cycles still owed in state
  task automatic test_random_stream;
    int  st = 4;
    int  left = 0;
    bit  dn;
    bit  c;
    bit  v;
    logic [1:0] o;
    logic [5:0] ex;
    for (int n = 0; n < 10000; n++) begin
      c = ($urandom_range(0, 39) != 0);
      v = 1'($urandom_range(0, 1));
      o = 2'($urandom_range(0, 3));
      cfg_done = c; req_valid = v; req_op = o;
      dn = 1'b0;
      if (!c) st = 0;
      else case (st)
        0: begin st = 1; left = P; end
        1, 2: begin left--; if (left == 0) begin st = 3; left = S; end end
        3: begin left--; if (left == 0) begin st = 4; dn = 1'b1; end end
        default: if (v) begin
          if (o == 2'b00) begin st = 1; left = P; end
          else if (o == 2'b01) begin st = 2; left = P; end
          else st = (o == 2'b10) ? 5 : 4;
        end
      endcase
      ex = m_out(st, dn);
      step();
      n_checks++;
      if ((ff_set && ff_reset) || (ff_clk_en && (ff_set || ff_reset))) begin
        n_fail++; $display("FAIL random_invariant[%0d]: set=%b reset=%b clk_en=%b", n, ff_set, ff_reset, ff_clk_en);
      end
      n_checks++;
      if (obs !== ex) begin n_fail++; $display("FAIL random_model[%0d]: got %b want %b", n, obs, ex); end
    end
    cfg_done = 1'b1; req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_done = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    test_reset();
    test_set();
    test_freeze();
    test_ignore_busy();
    test_cfg_drop();
    test_async_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
